spi_clkgen_mode: RTL and testbench

Parametrised SPI serial-clock and framing generator, successor to the single-mode SPI clock generator in the SPI host. From one `go` pulse it runs a complete frame: chip-select assertion, a programmable setup delay, exactly `nbits` SCLK cycles in any of the four CPOL/CPHA modes, and a trailing hold. It emits registered SCLK edge, sample and shift strobes for the SPI shift register, and drives `cs_n`, `busy` and `done` for the host control FSM.

---
 rtl/spi_clkgen_mode.sv | 230 +++++++++++++++++++++++
 tb/tb_spi_clkgen_mode.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_clkgen_mode.sv
// SPI serial-clock and framing generator: chip-select lead, nbits SCLK cycles in any CPOL/CPHA mode, trailing hold.
// Optional continuous back-to-back framing when SPI_CLKGEN_CONT_EN is defined.
module spi_clkgen_mode #(
    parameter int DIV_W  = 16,
    parameter int CNT_W  = 8,
    parameter int LEAD_W = 4
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              enable,
    input  logic              go,
    input  logic [DIV_W-1:0]  divider,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [CNT_W-1:0]  nbits,
    input  logic [LEAD_W-1:0] cs_lead,
    output logic              sclk,
    output logic              cs_n,
    output logic              pos_edge,
    output logic              neg_edge,
    output logic              sample,
    output logic              shift,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEAD,
        ST_RUN,
        ST_TRAIL
    } state_t;

    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
    localparam logic [LEAD_W-1:0] LEAD_ONE = LEAD_W'(1);
    localparam logic [CNT_W:0]    EDGE_ONE = (CNT_W+1)'(1);

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic [CNT_W-1:0]    nbits_q, nbits_d;
    logic [LEAD_W-1:0]   lead_cnt_q, lead_cnt_d;
    logic [CNT_W:0]      edge_cnt_q, edge_cnt_d;
    logic                sclk_q, sclk_d;
    logic                cs_n_q, cs_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pos_q, pos_d;
    logic                neg_q, neg_d;
    logic                sample_q, sample_d;
    logic                shift_q, shift_d;

    logic                tick;
    logic                accept;
    logic                edge_fire;
    logic                edge_leading;
    logic                edge_last;
    logic [CNT_W:0]      edge_next;

    assign tick      = (cnt_q == '0);
    assign accept    = go && enable && (nbits != '0);
    assign edge_next = edge_cnt_q + EDGE_ONE;

    always_comb begin
        state_d      = state_q;
        cnt_d        = tick ? div_q : (cnt_q - DIV_ONE);
        div_d        = div_q;
        cpol_d       = cpol_q;
        cpha_d       = cpha_q;
        nbits_d      = nbits_q;
        lead_cnt_d   = lead_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        sclk_d       = sclk_q;
        cs_n_d       = cs_n_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        sample_d     = 1'b0;
        shift_d      = 1'b0;
        edge_fire    = 1'b0;
        edge_leading = 1'b0;
        edge_last    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Configuration tracks the inputs while idle, so the accepting edge latches them.
                div_d      = divider;
                cpol_d     = cpol;
                cpha_d     = cpha;
                nbits_d    = nbits;
                lead_cnt_d = cs_lead;
                sclk_d     = cpol;
                cs_n_d     = 1'b1;
                busy_d     = 1'b0;
                if (accept) begin
                    cnt_d   = divider;
                    state_d = ST_LEAD;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            ST_LEAD: begin
                if (tick) begin
                    if (lead_cnt_q == '0) begin
                        state_d      = ST_RUN;
                        edge_cnt_d   = EDGE_ONE;
                        sclk_d       = ~cpol_q;
                        edge_fire    = 1'b1;
                        edge_leading = 1'b1;
                    end else begin
                        lead_cnt_d = lead_cnt_q - LEAD_ONE;
                    end
                end
            end

            ST_RUN: begin
                if (tick) begin
                    // Even edge count so far means the next edge leaves the idle level.
                    edge_leading = ~edge_cnt_q[0];
                    sclk_d       = edge_cnt_q[0] ? cpol_q : ~cpol_q;
                    edge_cnt_d   = edge_next;
                    edge_fire    = 1'b1;
                    edge_last    = (edge_next == {nbits_q, 1'b0});
                    if (edge_last) begin
`ifdef SPI_CLKGEN_CONT_EN
                        if (go && (nbits != '0)) begin
                            div_d      = divider;
                            cpol_d     = cpol;
                            cpha_d     = cpha;
                            nbits_d    = nbits;
                            lead_cnt_d = cs_lead;
                            cnt_d      = divider;
                            edge_cnt_d = '0;
                            done_d     = 1'b1;
                        end else begin
                            state_d = ST_TRAIL;
                        end
`else
                        state_d = ST_TRAIL;
`endif
                    end
                end
            end

            ST_TRAIL: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (edge_fire) begin
            sample_d = cpha_q ? ~edge_leading : edge_leading;
            shift_d  = cpha_q ? edge_leading : (~edge_leading & ~edge_last);
        end

        // Abort wins over everything, including a frame that would finish this cycle.
        if (!enable) begin
            state_d  = ST_IDLE;
            cs_n_d   = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            sample_d = 1'b0;
            shift_d  = 1'b0;
            sclk_d   = (state_q == ST_IDLE) ? cpol : cpol_q;
        end

        pos_d = sclk_d & ~sclk_q;
        neg_d = ~sclk_d & sclk_q;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '1;
            div_q      <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            nbits_q    <= '0;
            lead_cnt_q <= '0;
            edge_cnt_q <= '0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pos_q      <= 1'b0;
            neg_q      <= 1'b0;
            sample_q   <= 1'b0;
            shift_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            nbits_q    <= nbits_d;
            lead_cnt_q <= lead_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pos_q      <= pos_d;
            neg_q      <= neg_d;
            sample_q   <= sample_d;
            shift_q    <= shift_d;
        end
    end

    assign sclk     = sclk_q;
    assign cs_n     = cs_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pos_edge = pos_q;
    assign neg_edge = neg_q;
    assign sample   = sample_q;
    assign shift    = shift_q;

endmodule

// File: tb/tb_spi_clkgen_mode.sv
// Bench for spi_clkgen_mode: frame-time reference model compared every cycle, plus directed literal checks.
module tb_spi_clkgen_mode;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        enable;
    logic        go;
    logic [15:0] divider;
    logic        cpol;
    logic        cpha;
    logic [7:0]  nbits;
    logic [3:0]  cs_lead;
    logic        sclk, cs_n, pos_edge, neg_edge, sample, shift, busy, done;

    int checks = 0;
    int errors = 0;

    // Reference model state: position inside the frame measured in clk_in edges since accept.
    bit m_in_frame;
    int m_r;
    int f_div, f_n, f_lead;
    bit f_cpol, f_cpha;
    bit m_sclk, m_prev_sclk, m_cs_n, m_busy, m_done, m_pos, m_neg, m_sample, m_shift;

    spi_clkgen_mode dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .enable   (enable),
        .go       (go),
        .divider  (divider),
        .cpol     (cpol),
        .cpha     (cpha),
        .nbits    (nbits),
        .cs_lead  (cs_lead),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .pos_edge (pos_edge),
        .neg_edge (neg_edge),
        .sample   (sample),
        .shift    (shift),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_in = ~clk_in;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_in_frame  = 0;
        m_sclk      = 0;
        m_prev_sclk = 0;
        m_cs_n      = 1;
        m_busy      = 0;
        m_done      = 0;
        m_pos       = 0;
        m_neg       = 0;
        m_sample    = 0;
        m_shift     = 0;
    endtask

    task automatic model_step();
        int h, n2, tend, q, m, e;
        if (rst) begin
            model_reset();
            return;
        end
        m_done   = 0;
        m_sample = 0;
        m_shift  = 0;
        if (m_in_frame) begin
            if (!enable) begin
                m_in_frame = 0;
                m_sclk     = f_cpol;
                m_cs_n     = 1;
                m_busy     = 0;
                $display("frame aborted at r=%0d", m_r);
            end else begin
                m_r++;
                h    = f_div + 1;
                n2   = 2 * f_n;
                tend = (f_lead + n2 + 1) * h;
                if (m_r == tend) begin
                    m_in_frame = 0;
                    m_done     = 1;
                    m_cs_n     = 1;
                    m_busy     = 0;
                    m_sclk     = f_cpol;
                    $display("frame done: div=%0d cpol=%0d cpha=%0d nbits=%0d lead=%0d cycles=%0d",
                             f_div, f_cpol, f_cpha, f_n, f_lead, m_r);
                end else begin
                    q = m_r / h;
                    m = m_r % h;
                    e = q - f_lead;
                    if (e < 0) e = 0;
                    if (e > n2) e = n2;
                    m_sclk = f_cpol ^ e[0];
                    if (m == 0 && (q - f_lead) >= 1 && (q - f_lead) <= n2) begin
                        // Odd-numbered SCLK edges leave the idle level.
                        m_sample = f_cpha ? ~e[0] : e[0];
                        m_shift  = f_cpha ? e[0] : (~e[0] && e != n2);
                    end
                end
            end
        end else begin
            m_sclk = cpol;
            m_cs_n = 1;
            m_busy = 0;
            if (enable && go && nbits != 0) begin
                m_in_frame = 1;
                m_r        = 0;
                f_div      = int'(divider);
                f_n        = int'(nbits);
                f_lead     = int'(cs_lead);
                f_cpol     = cpol;
                f_cpha     = cpha;
                m_cs_n     = 0;
                m_busy     = 1;
            end
        end
        m_pos       = m_sclk & ~m_prev_sclk;
        m_neg       = ~m_sclk & m_prev_sclk;
        m_prev_sclk = m_sclk;
    endtask

    task automatic compare_all();
        check1("sclk", sclk, m_sclk);
        check1("cs_n", cs_n, m_cs_n);
        check1("busy", busy, m_busy);
        check1("done", done, m_done);
        check1("pos_edge", pos_edge, m_pos);
        check1("neg_edge", neg_edge, m_neg);
        check1("sample", sample, m_sample);
        check1("shift", shift, m_shift);
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
        compare_all();
    endtask

    task automatic start_frame(input int dv, input bit pol, input bit pha, input int nb, input int ld);
        divider = 16'(dv);
        cpol    = pol;
        cpha    = pha;
        nbits   = 8'(nb);
        cs_lead = 4'(ld);
        go      = 1;
        tick();
        go      = 0;
    endtask

    task automatic finish_frame();
        int guard;
        guard = 0;
        while (m_in_frame && guard < 2000) begin
            tick();
            guard++;
        end
        checks++;
        if (m_in_frame) begin
            errors++;
            $display("FAIL frame_timeout: frame still open after %0d cycles, required end", guard);
        end
    endtask

    logic [10:0] sclk_lit;
    logic [10:0] sample_lit;
    logic [10:0] shift_lit;
    logic [10:0] done_lit;

    initial begin
        rst     = 1;
        enable  = 0;
        go      = 0;
        divider = 0;
        cpol    = 0;
        cpha    = 0;
        nbits   = 0;
        cs_lead = 0;
        model_reset();

        tick();
        check1("reset_cnt_ones", &dut.cnt_q, 1'b1);
        check1("reset_cs_n", cs_n, 1'b1);
        rst    = 0;
        enable = 1;
        tick();
        tick();

        // Mode 0, divider 1, lead 0, nbits 2: literal waveform over r=1..10.
        sclk_lit   = 11'b00011001100;
        sample_lit = 11'b00001000100;
        shift_lit  = 11'b00000010000;
        done_lit   = 11'b10000000000;
        start_frame(1, 0, 0, 2, 0);
        for (int r = 1; r <= 10; r++) begin
            go = (r == 3);  // go while busy must be ignored
            tick();
            check1("lit0_sclk", sclk, sclk_lit[r]);
            check1("lit0_sample", sample, sample_lit[r]);
            check1("lit0_shift", shift, shift_lit[r]);
            check1("lit0_done", done, done_lit[r]);
        end
        go = 0;
        tick();

        // Mode 3, divider 0, nbits 8.
        cpol = 1;
        cpha = 1;
        tick();
        check1("lit3_idle_high", sclk, 1'b1);
        start_frame(0, 1, 1, 8, 0);
        for (int r = 1; r <= 17; r++) begin
            tick();
            if (r == 1) begin
                check1("lit3_first_neg", neg_edge, 1'b1);
                check1("lit3_first_shift", shift, 1'b1);
                check1("lit3_first_nosample", sample, 1'b0);
            end
            if (r == 2) begin
                check1("lit3_pos", pos_edge, 1'b1);
                check1("lit3_sample", sample, 1'b1);
            end
            if (r == 16) check1("lit3_not_done_yet", done, 1'b0);
            if (r == 17) check1("lit3_done", done, 1'b1);
        end
        tick();

        // cs_lead 3, divider 4: first SCLK edge at edge 20.
        start_frame(4, 0, 0, 1, 3);
        for (int r = 1; r <= 20; r++) begin
            tick();
            if (r == 1)  check1("lead_cs_low", cs_n, 1'b0);
            if (r == 19) check1("lead_sclk_before", sclk, 1'b0);
            if (r == 20) check1("lead_sclk_first", pos_edge, 1'b1);
        end
        finish_frame();
        tick();

        // nbits 0 with go: nothing happens.
        start_frame(2, 0, 0, 0, 0);
        check1("nbits0_busy", busy, 1'b0);
        check1("nbits0_cs_n", cs_n, 1'b1);
        tick();

        // Abort after the third SCLK edge, then a clean frame.
        start_frame(1, 0, 1, 4, 0);
        for (int r = 1; r <= 6; r++) tick();
        enable = 0;
        tick();
        check1("abort_cs_n", cs_n, 1'b1);
        check1("abort_busy", busy, 1'b0);
        check1("abort_sclk", sclk, 1'b0);
        check1("abort_done", done, 1'b0);
        enable = 1;
        tick();
        start_frame(1, 0, 1, 2, 1);
        finish_frame();
        check1("after_abort_done", done, 1'b1);
        tick();

        // Asynchronous reset in the middle of RUN.
        start_frame(2, 1, 0, 5, 0);
        for (int r = 1; r <= 7; r++) tick();
        rst = 1;
        #1;
        check1("rst_sclk", sclk, 1'b0);
        check1("rst_cs_n", cs_n, 1'b1);
        check1("rst_busy", busy, 1'b0);
        check1("rst_strobes", sample | shift | pos_edge | neg_edge | done, 1'b0);
        check1("rst_cnt_ones", &dut.cnt_q, 1'b1);
        model_reset();
        tick();
        rst = 0;
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            divider = 16'($urandom_range(0, 3));
            cpol    = 1'($urandom_range(0, 1));
            cpha    = 1'($urandom_range(0, 1));
            nbits   = 8'($urandom_range(0, 5));
            cs_lead = 4'($urandom_range(0, 3));
            enable  = ($urandom_range(0, 79) != 0);
            go      = ($urandom_range(0, 5) == 0);
`ifdef SPI_CLKGEN_CONT_EN
            if (m_in_frame) go = 0;
`endif
            tick();
        end
        enable = 1;
        go     = 0;
        finish_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
